// File: rtl/change_dispense_sequencer_if.sv
// Handshake bundle between the vending controller, the change sequencer and the coin hopper.
// The master modport is the controller/hopper side; the slave modport is the sequencer.
interface change_dispense_sequencer_if #(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 31
);
    logic                  i_start;
    logic [TOTAL_BITS-1:0] i_amount;
    logic [NUM_COINS-1:0]  i_coin_empty;
    logic                  i_coin_ack;
    logic                  o_coin_valid;
    logic [NUM_COINS-1:0]  o_coin_sel;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_short;
    logic                  o_fault;
    logic [TOTAL_BITS-1:0] o_remaining;

    modport master (
        output i_start, i_amount, i_coin_empty, i_coin_ack,
        input  o_coin_valid, o_coin_sel, o_busy, o_done, o_short, o_fault, o_remaining
    );

    modport slave (
        input  i_start, i_amount, i_coin_empty, i_coin_ack,
        output o_coin_valid, o_coin_sel, o_busy, o_done, o_short, o_fault, o_remaining
    );
endinterface

// File: rtl/change_dispense_sequencer.sv
// Greedy change dispenser: pays an amount back one coin per hopper handshake,
// largest non-empty denomination first, with an inter-coin gap and an ack timeout.
module change_dispense_sequencer #(
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_BITS  = 31,
    parameter int COIN_VAL0   = 100,
    parameter int COIN_VAL1   = 500,
    parameter int COIN_VAL2   = 1000,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    change_dispense_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_DISPENSE = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    // A zero value marks an index with no denomination; such slots are never eligible.
    function automatic logic [TOTAL_BITS-1:0] coin_val(input int k);
        case (k)
            0:       coin_val = TOTAL_BITS'(COIN_VAL0);
            1:       coin_val = TOTAL_BITS'(COIN_VAL1);
            2:       coin_val = TOTAL_BITS'(COIN_VAL2);
            default: coin_val = '0;
        endcase
    endfunction

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  coin_valid;
    logic [NUM_COINS-1:0]  coin_sel;
    logic                  short_q;
    logic                  fault_q;
    logic [TOTAL_BITS-1:0] remaining;

    logic [NUM_COINS-1:0]  eligible;
    logic                  pick_found;
    logic [NUM_COINS-1:0]  pick_sel;
    logic [TOTAL_BITS-1:0] ack_val;

    for (genvar k = 0; k < NUM_COINS; k++) begin : g_elig
        assign eligible[k] = (coin_val(k) != '0) && (coin_val(k) <= remaining)
                             && !bus.i_coin_empty[k];
    end

    // Later (larger) indices overwrite earlier ones, so the highest eligible coin wins.
    always_comb begin
        pick_found = 1'b0;
        pick_sel   = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (eligible[k]) begin
                pick_found  = 1'b1;
                pick_sel    = '0;
                pick_sel[k] = 1'b1;
            end
        end
    end

    always_comb begin
        ack_val = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_sel[k]) ack_val = ack_val | coin_val(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            coin_valid <= 1'b0;
            coin_sel   <= '0;
            short_q    <= 1'b0;
            fault_q    <= 1'b0;
            remaining  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        remaining <= bus.i_amount;
                        short_q   <= 1'b0;
                        fault_q   <= 1'b0;
                        state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    cnt <= '0;
                    if (pick_found) begin
                        coin_sel   <= pick_sel;
                        coin_valid <= 1'b1;
                        state      <= S_DISPENSE;
                    end else begin
                        short_q <= (remaining != '0);
                        state   <= S_DONE;
                    end
                end
                S_DISPENSE: begin
                    if (bus.i_coin_ack) begin
                        remaining  <= remaining - ack_val;
                        coin_valid <= 1'b0;
                        coin_sel   <= '0;
                        cnt        <= '0;
                        state      <= (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
                    end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        coin_valid <= 1'b0;
                        coin_sel   <= '0;
                        fault_q    <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_SELECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_coin_valid = coin_valid;
    assign bus.o_coin_sel   = coin_sel;
    assign bus.o_busy       = (state != S_IDLE);
    assign bus.o_done       = (state == S_DONE);
    assign bus.o_short      = short_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_remaining  = remaining;
endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Directed bench for change_dispense_sequencer; stimulus and sampling on the falling edge.
module tb_change_dispense_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    change_dispense_sequencer_if #(.NUM_COINS(3), .TOTAL_BITS(31)) bus ();

    change_dispense_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-run trace, cycle 1 = first falling edge after the edge that took i_start.
    logic [2:0]  r_sel [0:7];
    int          r_cyc [0:7];
    int          n_coins, valid_cnt, first_valid, done_cyc, done_cnt;
    logic [2:0]  first_sel;
    logic [30:0] done_rem;
    logic        done_short, done_fault, busy_c1, busy_after;

    task automatic run_seq(input logic [30:0] amt, input logic [2:0] empty,
                           input logic ack, input int inj_c);
        n_coins = 0; valid_cnt = 0; first_valid = 0; done_cyc = 0; done_cnt = 0;
        first_sel = '0; done_rem = '1; done_short = 1'bx; done_fault = 1'bx;
        busy_c1 = 1'b0; busy_after = 1'b1;
        bus.i_coin_empty = empty;
        bus.i_coin_ack   = ack;
        @(negedge clk);
        bus.i_start  = 1'b1;
        bus.i_amount = amt;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.i_start = 1'b0;
                busy_c1 = bus.o_busy;
            end
            if (bus.o_coin_valid) begin
                valid_cnt++;
                if (first_valid == 0) begin
                    first_valid = c;
                    first_sel   = bus.o_coin_sel;
                end
                if (ack && n_coins < 8) begin
                    r_sel[n_coins] = bus.o_coin_sel;
                    r_cyc[n_coins] = c;
                    n_coins++;
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc   = c;
                    done_rem   = bus.o_remaining;
                    done_short = bus.o_short;
                    done_fault = bus.o_fault;
                end
            end
            if (inj_c != 0 && c == inj_c) begin
                bus.i_start  = 1'b1;
                bus.i_amount = 31'd9999;
            end
            if (inj_c != 0 && c == inj_c + 1) bus.i_start = 1'b0;
            if (done_cyc != 0 && c == done_cyc + 1) begin
                busy_after = bus.o_busy;
                break;
            end
        end
        bus.i_start    = 1'b0;
        bus.i_coin_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_start = 1'b1; bus.i_amount = 31'd1000;
        bus.i_coin_empty = '0; bus.i_coin_ack = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.o_coin_valid, bus.o_coin_sel, bus.o_busy, bus.o_done, bus.o_short, bus.o_fault} !== 8'd0)
            $display("FAIL reset_flags got %b expected 0",
                     {bus.o_coin_valid, bus.o_coin_sel, bus.o_busy, bus.o_done, bus.o_short, bus.o_fault});
        else passed++;
        total++;
        if (bus.o_remaining !== 31'd0) $display("FAIL reset_remaining got %0d expected 0", bus.o_remaining);
        else passed++;
        bus.i_start = 1'b0; bus.i_coin_ack = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_greedy_1600();
        run_seq(31'd1600, 3'b000, 1'b1, 5);
        total++;
        if (n_coins !== 3) $display("FAIL t1_coins got %0d expected 3", n_coins); else passed++;
        total++;
        if ({r_sel[0], r_sel[1], r_sel[2]} !== 9'b100_010_001)
            $display("FAIL t1_sels got %b %b %b expected 100 010 001", r_sel[0], r_sel[1], r_sel[2]);
        else passed++;
        total++;
        if (r_cyc[0] !== 2 || r_cyc[1] !== 6 || r_cyc[2] !== 10)
            $display("FAIL t1_coin_cycles got %0d %0d %0d expected 2 6 10", r_cyc[0], r_cyc[1], r_cyc[2]);
        else passed++;
        total++;
        if (valid_cnt !== 3) $display("FAIL t1_valid_cycles got %0d expected 3", valid_cnt); else passed++;
        total++;
        if (done_cyc !== 14 || done_cnt !== 1)
            $display("FAIL t1_done got cyc %0d cnt %0d expected 14 1", done_cyc, done_cnt);
        else passed++;
        total++;
        if (done_rem !== 31'd0 || done_short !== 1'b0 || done_fault !== 1'b0)
            $display("FAIL t1_result got rem %0d short %b fault %b expected 0 0 0", done_rem, done_short, done_fault);
        else passed++;
        total++;
        if (busy_c1 !== 1'b1 || busy_after !== 1'b0)
            $display("FAIL t1_busy got %b/%b expected 1/0", busy_c1, busy_after);
        else passed++;
    endtask

    task automatic test_empty_tube();
        run_seq(31'd1500, 3'b100, 1'b1, 0);
        total++;
        if (n_coins !== 3 || {r_sel[0], r_sel[1], r_sel[2]} !== 9'b010_010_010)
            $display("FAIL t2_coins got %0d sels %b %b %b expected 3 x 010", n_coins, r_sel[0], r_sel[1], r_sel[2]);
        else passed++;
        total++;
        if (done_cyc !== 14 || done_rem !== 31'd0 || done_short !== 1'b0)
            $display("FAIL t2_done got cyc %0d rem %0d short %b expected 14 0 0", done_cyc, done_rem, done_short);
        else passed++;
    endtask

    task automatic test_short();
        run_seq(31'd250, 3'b000, 1'b1, 0);
        total++;
        if (n_coins !== 2 || {r_sel[0], r_sel[1]} !== 6'b001_001)
            $display("FAIL t3_coins got %0d sels %b %b expected 2 x 001", n_coins, r_sel[0], r_sel[1]);
        else passed++;
        total++;
        if (done_cyc !== 10 || done_rem !== 31'd50 || done_short !== 1'b1 || done_fault !== 1'b0)
            $display("FAIL t3_done got cyc %0d rem %0d short %b fault %b expected 10 50 1 0",
                     done_cyc, done_rem, done_short, done_fault);
        else passed++;
    endtask

    task automatic test_timeout();
        run_seq(31'd700, 3'b000, 1'b0, 0);
        total++;
        if (valid_cnt !== 16 || first_valid !== 2 || first_sel !== 3'b010)
            $display("FAIL t4_valid got cnt %0d first %0d sel %b expected 16 2 010", valid_cnt, first_valid, first_sel);
        else passed++;
        total++;
        if (done_cyc !== 18 || done_rem !== 31'd700 || done_fault !== 1'b1 || done_short !== 1'b0)
            $display("FAIL t4_done got cyc %0d rem %0d fault %b short %b expected 18 700 1 0",
                     done_cyc, done_rem, done_fault, done_short);
        else passed++;
    endtask

    task automatic test_zero_amount();
        run_seq(31'd0, 3'b000, 1'b1, 0);
        total++;
        if (done_cyc !== 2 || valid_cnt !== 0)
            $display("FAIL t5_zero got done %0d valid %0d expected 2 0", done_cyc, valid_cnt);
        else passed++;
        total++;
        if (done_short !== 1'b0 || done_fault !== 1'b0 || done_rem !== 31'd0)
            $display("FAIL t5_flags got short %b fault %b rem %0d expected 0 0 0", done_short, done_fault, done_rem);
        else passed++;
    endtask

    task automatic test_reset_mid_dispense();
        bus.i_coin_empty = '0;
        bus.i_coin_ack   = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_amount = 31'd1000;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.o_coin_valid !== 1'b1 || bus.o_coin_sel !== 3'b100)
            $display("FAIL t6_pre got valid %b sel %b expected 1 100", bus.o_coin_valid, bus.o_coin_sel);
        else passed++;
        reset = 1'b1;
        bus.i_coin_ack = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.o_coin_valid, bus.o_coin_sel, bus.o_busy, bus.o_done, bus.o_short, bus.o_fault} !== 8'd0
            || bus.o_remaining !== 31'd0)
            $display("FAIL t6_reset got flags %b rem %0d expected 0 0",
                     {bus.o_coin_valid, bus.o_coin_sel, bus.o_busy, bus.o_done, bus.o_short, bus.o_fault},
                     bus.o_remaining);
        else passed++;
        reset = 1'b0;
        bus.i_coin_ack = 1'b0;
        run_seq(31'd500, 3'b000, 1'b1, 0);
        total++;
        if (n_coins !== 1 || r_sel[0] !== 3'b010 || r_cyc[0] !== 2)
            $display("FAIL t6_restart_coin got %0d sel %b cyc %0d expected 1 010 2", n_coins, r_sel[0], r_cyc[0]);
        else passed++;
        total++;
        if (done_cyc !== 6 || done_rem !== 31'd0 || done_short !== 1'b0 || done_fault !== 1'b0)
            $display("FAIL t6_restart_done got cyc %0d rem %0d short %b fault %b expected 6 0 0 0",
                     done_cyc, done_rem, done_short, done_fault);
        else passed++;
    endtask

    initial begin
        total = 0; passed = 0;
        reset = 1'b1;
        bus.i_start = 1'b0; bus.i_amount = '0;
        bus.i_coin_empty = '0; bus.i_coin_ack = 1'b0;
        test_reset();
        test_greedy_1600();
        test_empty_tube();
        test_short();
        test_timeout();
        test_zero_amount();
        test_reset_mid_dispense();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/change_dispense_sequencer.md
Name: change_dispense_sequencer

Overview:
Sequences the physical return of change after a refund or wait-time expiry. It receives a change amount and drives a coin hopper one coin per handshake. Denominations are chosen greedily, highest first, and empty hopper tubes are skipped. The block sits between the vending controller, which issues start with the amount, and the coin hopper interface. It reports completion, any unpaid remainder, and a hopper fault.

Parameters:
NUM_COINS, 3, number of denominations (index 0 = smallest)
TOTAL_BITS, 31, width of amount/remaining arithmetic
COIN_VAL0, 100, value of coin index 0
COIN_VAL1, 500, value of coin index 1
COIN_VAL2, 1000, value of coin index 2
GAP_CYCLES, 2, idle cycles between consecutive coins (0 allowed)
ACK_TIMEOUT, 16, cycles o_coin_valid may wait for ack before fault

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_start  input  1  request to dispense i_amount; honoured only in IDLE
i_amount  input  TOTAL_BITS  change to return, sampled with i_start
i_coin_empty  input  NUM_COINS  per-denomination tube empty flag
i_coin_ack  input  1  hopper accepted the coin currently offered
o_coin_valid  output  1  coin request to hopper
o_coin_sel  output  NUM_COINS  one-hot denomination of current request
o_busy  output  1  sequence in progress (any state except IDLE)
o_done  output  1  one-cycle completion pulse
o_short  output  1  with o_done: remainder could not be paid
o_fault  output  1  with o_done: hopper ack timeout
o_remaining  output  TOTAL_BITS  amount still owed; holds until next start

Behaviour:
- Reset: synchronous, active-high, wins over all other inputs. State=IDLE; o_coin_valid, o_coin_sel, o_busy, o_done, o_short, o_fault, o_remaining and internal counters all 0. Reset during DISPENSE drops o_coin_valid at that edge; no decrement.
- States: IDLE, SELECT, DISPENSE, GAP, DONE. All outputs are registered or decoded from state (Moore); no combinational input-to-output path.
- IDLE: i_start=1 at edge t -> o_remaining<=i_amount, clear o_short/o_fault, state SELECT in cycle t+1. i_start in any other state is ignored.
- SELECT (1 cycle): pick the highest k with COIN_VALk <= o_remaining and i_coin_empty[k]=0.
  - Found -> DISPENSE; o_coin_sel=onehot(k), o_coin_valid=1 from cycle t+2.
  - None -> DONE; o_short<=(o_remaining!=0).
  - i_coin_empty is sampled only here.
- DISPENSE: o_coin_valid and o_coin_sel held stable until the edge where i_coin_ack=1.
  - On ack: o_remaining<=o_remaining-COIN_VALk, drop valid, go to GAP, or to SELECT if GAP_CYCLES=0.
  - Ack is counted only in DISPENSE; ack in other states is ignored.
  - Wait counter starts at 0 on entry. If ACK_TIMEOUT cycles pass with no ack: drop valid, o_fault<=1, o_remaining unchanged, go to DONE.
- GAP: exactly GAP_CYCLES cycles with valid=0, then SELECT.
- DONE: exactly one cycle with o_done=1; o_short and o_fault are valid this cycle and held until next start. Then IDLE.
- Arithmetic: unsigned. Subtraction cannot underflow because selection guarantees COIN_VALk <= remaining. No multi-coin batching; one coin per handshake.
- Timing: amount 0 gives o_done at cycle t+2 with no coin request. Ack in the first valid cycle is legal (single-cycle handshake).

Test Plan:
1. Amount 1600, none empty, ack tied high, GAP=2 -> sel 100b,010b,001b (1000,500,100) each one valid cycle, 2-cycle gaps, o_done with o_remaining=0, short=0, fault=0.
2. Amount 1500, i_coin_empty=100b -> three coins sel=010b (500), remaining 0, short=0.
3. Amount 250 -> two coins sel=001b, then o_done with short=1, o_remaining=50.
4. Amount 700, ack held 0 -> sel=010b valid for 16 cycles, then valid drops, o_done with fault=1, o_remaining=700.
5. Amount 0, start at t -> o_done at t+2, o_coin_valid never asserts, short=0; second i_start while busy in case 1 has no effect on sequence or o_remaining.
6. Reset asserted mid-DISPENSE with amount 1000 -> next cycle all outputs 0, state IDLE; fresh start 500 completes normally.
